// File: rtl/srff_rr_arbiter.sv
// srff_rr_arbiter: round-robin arbiter whose grant is a bank of set/reset
// flags, with a per-grant hold timeout and one dead cycle between owners.
module srff_rr_arbiter #(
  parameter int W   = 4,
  parameter int TMO = 16,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [W-1:0]  req,
  input  logic [W-1:0]  rel,
  output logic [W-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          tmo_err
);

  localparam int CWR = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int CW  = (CWR > 1) ? CWR : 1;

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] CLIM  = (TMO > 0) ? CW'(TMO - 1) : '0;
  localparam logic [IW-1:0] ILAST = IW'(W - 1);
  localparam logic [W-1:0]  ONE   = W'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic [IW-1:0] pick, pick_hi, pick_lo;
  logic          hi_hit;
  logic [IW-1:0] ptr_nxt;
  logic          own_rel, own_req;

  assign own_rel = |(rel & gnt_q);
  assign own_req = |(req & gnt_q);
  assign ptr_nxt = (gnt_id_q == ILAST) ? '0 : gnt_id_q + 1'b1;

  // rotating priority: lowest request at or above ptr, else lowest overall
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_hit  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = IW'(i);
        if (IW'(i) >= ptr_q) begin
          pick_hi = IW'(i);
          hi_hit  = 1'b1;
        end
      end
    end
    pick = hi_hit ? pick_hi : pick_lo;
  end

  // next-state: award in IDLE, release/timeout in GRANT, one dead cycle
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d    = ONE << pick;
          gnt_id_d = pick;
          cnt_d    = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (own_rel || !own_req) begin
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          state_d = GAP;
        end else if ((TMO > 0) && (cnt_q == CLIM)) begin
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          tmo_d   = 1'b1;
          state_d = GAP;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state and grant flag registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = |gnt_q;
  assign tmo_err = tmo_q;

  a_onehot : assert property (@(posedge clk) disable iff (clr)
    $onehot0(gnt_q));
  a_busy : assert property (@(posedge clk) disable iff (clr)
    busy == (|gnt_q));
  a_tmo : assert property (@(posedge clk) disable iff (clr)
    tmo_q |-> (gnt_q == '0));
  a_id : assert property (@(posedge clk) disable iff (clr)
    (gnt_q == '0) || (gnt_q == (ONE << gnt_id_q)));

endmodule

// File: tb/tb_srff_rr_arbiter.sv
// tb_srff_rr_arbiter: directed vectors for a W=4/TMO=8 and a W=1/TMO=0
// arbiter, expectations queued by the driver and popped by a monitor.
module tb_srff_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [3:0] req, rel, gnt;
  logic [1:0] gnt_id;
  logic       busy, tmo_err;

  logic       clr1;
  logic [0:0] req1, rel1, gnt1, gid1;
  logic       busy1, tmo1;

  srff_rr_arbiter #(.W(4), .TMO(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .tmo_err (tmo_err)
  );

  srff_rr_arbiter #(.W(1), .TMO(0)) dut1 (
    .clk     (clk),
    .clr     (clr1),
    .req     (req1),
    .rel     (rel1),
    .gnt     (gnt1),
    .gnt_id  (gid1),
    .busy    (busy1),
    .tmo_err (tmo1)
  );

  typedef struct {
    bit         sel;
    logic [3:0] g;
    logic [1:0] id;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // monitor: one expectation per clock, sampled just after the edge
  always @(posedge clk) begin : mon
    exp_t e;
    logic ok;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (!e.sel) begin
        ok = (gnt === e.g) && (gnt_id === e.id) &&
             (busy === (e.g != 4'h0)) && (tmo_err === e.t);
        if (ok) passes++;
        else $display("FAIL %s: got gnt=%b id=%0d busy=%b tmo=%b, want gnt=%b id=%0d busy=%b tmo=%b",
                      e.nm, gnt, gnt_id, busy, tmo_err,
                      e.g, e.id, (e.g != 4'h0), e.t);
      end else begin
        ok = (gnt1 === e.g[0:0]) && (gid1 === 1'b0) &&
             (busy1 === e.g[0]) && (tmo1 === e.t);
        if (ok) passes++;
        else $display("FAIL %s: got gnt=%b id=%0d busy=%b tmo=%b, want gnt=%b id=0 busy=%b tmo=%b",
                      e.nm, gnt1, gid1, busy1, tmo1,
                      e.g[0], e.g[0], e.t);
      end
    end
  end

  task automatic step(input logic c, input logic [3:0] rq,
                      input logic [3:0] rl, input logic [3:0] eg,
                      input logic [1:0] eid, input logic et,
                      input string nm);
    exp_t e;
    @(negedge clk);
    clr = c;
    req = rq;
    rel = rl;
    e.sel = 1'b0;
    e.g   = eg;
    e.id  = eid;
    e.t   = et;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step1(input logic c, input logic rq, input logic rl,
                       input logic eg, input logic et, input string nm);
    exp_t e;
    @(negedge clk);
    clr1 = c;
    req1 = rq;
    rel1 = rl;
    e.sel = 1'b1;
    e.g   = {3'b000, eg};
    e.id  = 2'd0;
    e.t   = et;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drive
    int         order[5];
    logic [3:0] oh;
    logic [1:0] o;
    order = '{0, 1, 2, 3, 0};
    clr  = 1'b1;
    req  = 4'h0;
    rel  = 4'h0;
    clr1 = 1'b1;
    req1 = 1'b0;
    rel1 = 1'b0;

    // reset with all requests pending
    step(1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, "rst0");
    step(1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, "rst1");
    step(1'b0, 4'hF, 4'h0, 4'h1, 2'd0, 1'b0, "rst_exit");

    // round robin, each owner holds 2 cycles then pulses rel
    for (int i = 0; i < 5; i++) begin
      o  = 2'(order[i]);
      oh = 4'b0001 << o;
      if (i > 0) step(1'b0, 4'hF, 4'h0, oh, o, 1'b0, "rr_award");
      step(1'b0, 4'hF, 4'h0, oh, o, 1'b0, "rr_hold");
      step(1'b0, 4'hF, oh, 4'h0, o, 1'b0, "rr_rel");
      step(1'b0, 4'hF, 4'h0, 4'h0, o, 1'b0, "rr_gap");
    end

    // timeout: requester 2 alone, never released
    step(1'b0, 4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "tmo_award");
    repeat (7) step(1'b0, 4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "tmo_hold");
    step(1'b0, 4'h4, 4'h0, 4'h0, 2'd2, 1'b1, "tmo_fire");
    step(1'b0, 4'h4, 4'h0, 4'h0, 2'd2, 1'b0, "tmo_gap");
    step(1'b0, 4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "tmo_regrant");

    // release coincides with the timeout cycle
    repeat (7) step(1'b0, 4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "col_hold");
    step(1'b0, 4'h4, 4'h4, 4'h0, 2'd2, 1'b0, "col_rel");
    step(1'b0, 4'h3, 4'h0, 4'h0, 2'd2, 1'b0, "col_gap");

    // foreign release is ignored
    step(1'b0, 4'h3, 4'h0, 4'h1, 2'd0, 1'b0, "fr_award");
    step(1'b0, 4'h3, 4'h2, 4'h1, 2'd0, 1'b0, "fr_foreign");
    step(1'b0, 4'h3, 4'h0, 4'h1, 2'd0, 1'b0, "fr_hold");
    step(1'b0, 4'h3, 4'h1, 4'h0, 2'd0, 1'b0, "fr_rel");
    step(1'b0, 4'h3, 4'h0, 4'h0, 2'd0, 1'b0, "fr_gap");
    step(1'b0, 4'h3, 4'h0, 4'h2, 2'd1, 1'b0, "fr_next");

    // request drop releases, pointer wraps after owner 3
    step(1'b0, 4'h8, 4'h0, 4'h0, 2'd1, 1'b0, "drop1");
    step(1'b0, 4'h8, 4'h0, 4'h0, 2'd1, 1'b0, "drop1_gap");
    step(1'b0, 4'h8, 4'h0, 4'h8, 2'd3, 1'b0, "own3");
    step(1'b0, 4'h8, 4'h0, 4'h8, 2'd3, 1'b0, "own3_hold");
    step(1'b0, 4'h0, 4'h0, 4'h0, 2'd3, 1'b0, "drop3");
    step(1'b0, 4'hF, 4'h0, 4'h0, 2'd3, 1'b0, "drop3_gap");
    step(1'b0, 4'hF, 4'h0, 4'h1, 2'd0, 1'b0, "ptr_wrap");
    step(1'b0, 4'hF, 4'h1, 4'h0, 2'd0, 1'b0, "rel0");
    step(1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, "rel0_gap");
    step(1'b0, 4'hF, 4'h0, 4'h2, 2'd1, 1'b0, "own1");
    step(1'b0, 4'hF, 4'h0, 4'h2, 2'd1, 1'b0, "own1_hold");

    // clear mid-grant, next award restarts from pointer 0
    step(1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, "clr_mid");
    step(1'b0, 4'hD, 4'h0, 4'h1, 2'd0, 1'b0, "clr_restart");
    step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, "idle_end");

    // single requester, no timeout
    step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1_award");
    repeat (20) step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1_hold");
    step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "w1_rel");
    step1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "w1_gap");
    step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1_regrant");
    step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1_hold2");
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w1_drop");

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, want 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
